lcd_write_arbiter: RTL and testbench
====================================

// Module: lcd_write_arbiter
// PURPOSE
//   Shares the single 9-bit LCD SPI write engine (lcd_write) between NUM_REQ requesters
//   (index 0 = lcd_init, then picture/row/char show engines). Grants one requester at a
//   time, forwards its words with an en_write/wr_done handshake and routes wr_done back.
//   Round-robin between eligible requesters; bursts are capped so no stream starves the rest.
//   Only requester 0 is eligible until init_done; replaces the fixed init/show mux in control.
// PARAMETERS
//   NUM_REQ      3     number of requesters (2..8); index 0 is the init requester
//   DATA_W       9     word width: {dc, byte[7:0]} as consumed by lcd_write
//   MAX_BURST    1024  max words per grant before forced re-arbitration (>=1)
//   CNT_W        11    burst counter width, must hold MAX_BURST
// PORTS
//   sys_clk_50MHz  in   1               system clock, all logic on rising edge
//   sys_rst_n      in   1               asynchronous active-low reset
//   init_done      in   1               LCD init sequence finished (level)
//   req            in   NUM_REQ         per-requester bus request (level, held for whole burst)
//   wr_req         in   NUM_REQ         per-requester 1-cycle word strobe
//   wr_data        in   NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
//   grant          out  NUM_REQ         one-hot grant (registered)
//   req_wr_done    out  NUM_REQ         wr_done routed to the granted requester
//   data           out  DATA_W          word to lcd_write
//   en_write       out  1               1-cycle write strobe to lcd_write
//   wr_done        in   1               1-cycle completion pulse from lcd_write
//   busy           out  1               high in every state except IDLE
//   proto_err      out  1               1-cycle pulse on an illegal wr_req
// BEHAVIOUR
//   Reset: grant=0, req_wr_done=0, data=0, en_write=0, busy=0, proto_err=0, state=IDLE,
//     burst_cnt=0, last=NUM_REQ-1 (first search starts at requester 0). Reset mid-word drops it.
//   Eligible(i) = req[i] & (init_done | i==0).
//   FSM IDLE/GRANT/WAIT_DONE/RELEASE:
//   - IDLE: if any eligible, pick the first eligible index scanning last+1, last+2, ... (mod
//     NUM_REQ); grant[g] set at next edge, burst_cnt=0 -> GRANT. req->grant latency 1 cycle.
//   - GRANT: wr_req[g]=1 -> latch wr_data[g] into data; en_write=1 next cycle for exactly one
//     cycle -> WAIT_DONE. Else if !req[g] or (g!=0 & !init_done) -> RELEASE.
//     wr_req[g] and falling req[g] in the same cycle: the word is accepted.
//   - WAIT_DONE: hold data stable. On wr_done: burst_cnt+1; if burst_cnt+1==MAX_BURST, or !req[g],
//     or (g!=0 & !init_done) -> RELEASE, else -> GRANT. No timeout.
//   - RELEASE: grant=0, last=g; one dead cycle -> IDLE (re-arbitration takes >=2 cycles).
//   req_wr_done = {NUM_REQ{wr_done}} & grant (combinational, same cycle as wr_done);
//     wr_done outside WAIT_DONE is ignored and not routed.
//   data retains the last word until the next accepted one; only en_write qualifies it.
//   proto_err (registered, 1 cycle later): wr_req[i] with grant[i]=0, or wr_req[g] while in
//     WAIT_DONE or RELEASE; the word is dropped and en_write stays 0.
//   init_done falling while a non-zero requester is granted: any in-flight word completes,
//     then RELEASE.
//   At most one en_write per wr_done; en_write never rises while in WAIT_DONE.
// TESTING
//   1 init gating: init_done=0, req=3'b111 -> grant=3'b001 only; 1 and 2 never granted
//     until init_done=1.
//   2 round-robin: init_done=1, req=3'b111, each writes 1 word then drops req, re-raises
//     -> grant sequence 001,010,100,001.
//   3 burst cap MAX_BURST=4: req[1] held, 6 words queued, req[2]=1 -> RELEASE after 4th wr_done,
//     grant=100, then back to 010 for the remaining 2 words.
//   4 handshake: grant=010, wr_req[1] with word 9'h12C -> en_write 1 cycle later for 1 cycle,
//     data=9'h12C until wr_done (model latency 18 cycles); req_wr_done=3'b010 same cycle
//     as wr_done.
//   5 protocol error: grant=001, wr_req[2] pulse -> proto_err 1 cycle later, en_write stays 0,
//     grant unchanged.
//   6 reset mid-word: assert sys_rst_n=0 in WAIT_DONE -> all outputs 0 at once; after release
//     with req=3'b110, init_done=1 -> grant=010 first.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares the single lcd_write SPI engine between NUM_REQ word producers.
// Requester 0 (lcd_init) is the only eligible one until init_done; after that, arbitration
// is round-robin and bursts are capped at MAX_BURST words.
module lcd_write_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int DATA_W    = 9,
   parameter int MAX_BURST = 1024,
   parameter int CNT_W     = 11
) (
   input  logic                        sys_clk_50MHz,
   input  logic                        sys_rst_n,
   input  logic                        init_done,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          wr_req,
   input  logic [NUM_REQ*DATA_W-1:0]   wr_data,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          req_wr_done,
   output logic [DATA_W-1:0]           data,
   output logic                        en_write,
   input  logic                        wr_done,
   output logic                        busy,
   output logic                        proto_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT_DONE,
      RELEASE
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    cur;
   logic [IDX_W-1:0]    last;
   logic [IDX_W-1:0]    pick_idx;
   logic [IDX_W-1:0]    scan_idx;
   logic                pick_valid;
   logic [CNT_W-1:0]    burst_cnt;
   logic [CNT_W-1:0]    burst_next;
   logic [NUM_REQ-1:0]  eligible;
   logic [DATA_W-1:0]   cur_word;
   logic                cur_req;
   logic                cur_wr;
   logic                cur_allowed;
   logic                release_now;

   // Only requester 0 may use the bus before the panel is initialised.
   assign eligible    = req & {{(NUM_REQ-1){init_done}}, 1'b1};

   // grant is one-hot in GRANT/WAIT_DONE, so masking with it selects the owner's signals.
   assign cur_req     = |(req & grant);
   assign cur_wr      = |(wr_req & grant);
   assign cur_allowed = grant[0] | init_done;
   assign burst_next  = burst_cnt + 1'b1;
   assign release_now = (burst_next == CNT_W'(MAX_BURST)) | ~cur_req | ~cur_allowed;

   assign busy        = (state != IDLE);

   // Completion pulses go only to the owner, and only while a word is actually in flight.
   assign req_wr_done = {NUM_REQ{wr_done & (state == WAIT_DONE)}} & grant;

   // Round-robin search: first eligible index after the last owner, wrapping around.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!pick_valid && eligible[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   // Word mux: picks the packed word of whichever requester currently holds the grant.
   always_comb begin
      cur_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            cur_word = wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Arbitration FSM with registered grant, word, strobe and error outputs.
   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         data      <= '0;
         en_write  <= 1'b0;
         proto_err <= 1'b0;
         burst_cnt <= '0;
         cur       <= '0;
         last      <= IDX_W'(NUM_REQ - 1);
      end else begin
         en_write  <= 1'b0;
         proto_err <= (|(wr_req & ~grant)) | ((state == WAIT_DONE) & cur_wr);
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  cur       <= pick_idx;
                  burst_cnt <= '0;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (cur_wr) begin
                  data     <= cur_word;
                  en_write <= 1'b1;
                  state    <= WAIT_DONE;
               end else if (!cur_req || !cur_allowed) begin
                  grant <= '0;
                  last  <= cur;
                  state <= RELEASE;
               end
            end
            WAIT_DONE: begin
               if (wr_done) begin
                  burst_cnt <= burst_next;
                  if (release_now) begin
                     grant <= '0;
                     last  <= cur;
                     state <= RELEASE;
                  end else begin
                     state <= GRANT;
                  end
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: table-driven arbitration vectors, hand-written handshake sequences
// and a randomized multi-requester run scored against a queue-level reference model.
module tb_lcd_write_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int DATA_W    = 9;
   localparam int MAX_BURST = 4;
   localparam int CNT_W     = 3;

   logic                      clk;
   logic                      rst_n;
   logic                      init_done;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        wr_req;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        grant;
   logic [NUM_REQ-1:0]        req_wr_done;
   logic [DATA_W-1:0]         data;
   logic                      en_write;
   logic                      wr_done;
   logic                      busy;
   logic                      proto_err;

   int checks = 0;
   int errors = 0;

   lcd_write_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) dut (
      .sys_clk_50MHz (clk),
      .sys_rst_n     (rst_n),
      .init_done     (init_done),
      .req           (req),
      .wr_req        (wr_req),
      .wr_data       (wr_data),
      .grant         (grant),
      .req_wr_done   (req_wr_done),
      .data          (data),
      .en_write      (en_write),
      .wr_done       (wr_done),
      .busy          (busy),
      .proto_err     (proto_err)
   );

   // 50 MHz system clock.
   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic       init;
      logic [2:0] req;
      logic [2:0] exp_grant;
   } vec_t;

   vec_t vecs [0:11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic idn, input logic [2:0] r, input logic [2:0] wq);
      init_done = idn;
      req       = r;
      wr_req    = wq;
   endtask

   // Waits a bounded number of cycles for a grant pattern, then compares once.
   task automatic wait_grant(input string name, input logic [2:0] exp, input int budget);
      for (int c = 0; c < budget && grant !== exp; c++) tick();
      check_output(name, grant, exp);
   endtask

   // One complete word from requester i, with lcd_write answering lat cycles after en_write.
   task automatic do_word(input int i, input logic [8:0] w, input int lat);
      wr_req[i]            = 1'b1;
      wr_data[i*DATA_W +: DATA_W] = w;
      tick();
      wr_req = '0;
      check_output("en_write_rise", en_write, 1);
      check_output("data_latched", data, w);
      for (int c = 0; c < lat; c++) begin
         tick();
         check_output("en_write_single", en_write, 0);
         check_output("data_hold", data, w);
      end
      wr_done = 1'b1;
      #1;
      check_output("req_wr_done_route", req_wr_done, 3'b001 << i);
      tick();
      wr_done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      apply_stimulus(1'b0, 3'b000, 3'b000);
      wr_done = 1'b0;
      wr_data = '0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [2:0] rr_pick(input logic [2:0] r, input int last_idx);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (last_idx + k) % NUM_REQ;
         if (r[j]) return 3'(1 << j);
      end
      return 3'b000;
   endfunction

   function automatic int idx_of(input logic [2:0] g);
      for (int k = 0; k < NUM_REQ; k++) if (g[k]) return k;
      return 0;
   endfunction

   // Randomized run: each requester owns a queue of words; the scoreboard checks order,
   // ownership, round-robin choice, burst cap, routing and eventual delivery of everything.
   task automatic random_run();
      int         total [NUM_REQ];
      int         head [NUM_REQ];
      int         exp_ptr [NUM_REQ];
      int         start [NUM_REQ];
      bit         outstanding [NUM_REQ];
      logic [8:0] words [NUM_REQ][16];
      int         last_g  = NUM_REQ - 1;
      int         burst   = 0;
      int         pending = 0;
      int         countdown = 0;
      int         g;
      bit         done = 0;
      logic [8:0] latched = '0;
      logic [2:0] prev_grant = '0;
      logic [2:0] prev_req = '0;

      for (int i = 0; i < NUM_REQ; i++) begin
         total[i]       = $urandom_range(3, 12);
         start[i]       = $urandom_range(0, 15);
         head[i]        = 0;
         exp_ptr[i]     = 0;
         outstanding[i] = 0;
         for (int k = 0; k < 16; k++) words[i][k] = 9'($urandom);
      end
      init_done = 1'b1;

      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         tick();
         check_output("rand_no_proto_err", proto_err, 0);
         check_output("rand_grant_onehot", ($countones(grant) <= 1), 1);
         if (prev_grant == 3'b000 && grant != 3'b000) begin
            check_output("rand_rr_order", grant, rr_pick(prev_req, last_g));
            last_g = idx_of(grant);
            burst  = 0;
         end
         wr_done = 1'b0;
         if (en_write) begin
            g = idx_of(grant);
            burst++;
            check_output("rand_burst_cap", (burst <= MAX_BURST), 1);
            check_output("rand_no_overlap", pending, 0);
            check_output("rand_word_expected", (exp_ptr[g] < total[g]), 1);
            if (exp_ptr[g] < total[g]) check_output("rand_word_data", data, words[g][exp_ptr[g]]);
            exp_ptr[g]++;
            pending   = 1;
            countdown = $urandom_range(0, 5);
            latched   = data;
         end else if (pending != 0) begin
            if (countdown == 0) begin
               check_output("rand_data_hold", data, latched);
               wr_done = 1'b1;
               pending = 0;
            end else begin
               countdown--;
            end
         end
         wr_data = 27'($urandom);
         wr_req  = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && !outstanding[i] && head[i] < total[i] && req[i]) begin
               wr_req[i] = 1'b1;
               wr_data[i*DATA_W +: DATA_W] = words[i][head[i]];
               outstanding[i] = 1;
            end
         end
         #1;
         check_output("rand_req_wr_done", req_wr_done, wr_done ? grant : 3'b000);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_wr_done[i]) begin
               outstanding[i] = 0;
               head[i]++;
            end
            req[i] = (cyc >= start[i]) && (head[i] < total[i]);
         end
         prev_grant = grant;
         prev_req   = req;
         done = (pending == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] != total[i] || exp_ptr[i] != total[i]) done = 0;
         end
      end
      check_output("rand_all_delivered", done, 1);
      for (int i = 0; i < NUM_REQ; i++) check_output("rand_word_count", exp_ptr[i], total[i]);
   endtask

   // Main sequence: reset, arbitration table, hand-written corner cases, randomized run.
   initial begin
      vecs[0]  = '{1'b0, 3'b111, 3'b001};
      vecs[1]  = '{1'b0, 3'b110, 3'b000};
      vecs[2]  = '{1'b0, 3'b111, 3'b001};
      vecs[3]  = '{1'b1, 3'b111, 3'b010};
      vecs[4]  = '{1'b1, 3'b111, 3'b100};
      vecs[5]  = '{1'b1, 3'b111, 3'b001};
      vecs[6]  = '{1'b1, 3'b101, 3'b100};
      vecs[7]  = '{1'b1, 3'b011, 3'b001};
      vecs[8]  = '{1'b1, 3'b100, 3'b100};
      vecs[9]  = '{1'b1, 3'b010, 3'b010};
      vecs[10] = '{1'b1, 3'b001, 3'b001};
      vecs[11] = '{1'b1, 3'b000, 3'b000};

      rst_n   = 1'b0;
      wr_done = 1'b0;
      wr_data = '0;
      apply_stimulus(1'b0, 3'b000, 3'b000);
      #25;
      check_output("reset_grant", grant, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_en_write", en_write, 0);
      check_output("reset_data", data, 0);
      check_output("reset_proto_err", proto_err, 0);
      check_output("reset_req_wr_done", req_wr_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 12; v++) begin
         apply_stimulus(vecs[v].init, vecs[v].req, 3'b000);
         tick();
         check_output("table_grant", grant, vecs[v].exp_grant);
         check_output("table_busy", busy, (vecs[v].exp_grant != 3'b000));
         apply_stimulus(vecs[v].init, 3'b000, 3'b000);
         tick();
         tick();
         check_output("table_release", busy, 0);
      end

      apply_stimulus(1'b1, 3'b010, 3'b000);
      tick();
      check_output("hs_grant", grant, 3'b010);
      do_word(1, 9'h12C, 18);
      check_output("hs_grant_kept", grant, 3'b010);
      wr_done = 1'b1;
      #1;
      check_output("stray_done_not_routed", req_wr_done, 0);
      tick();
      wr_done = 1'b0;
      check_output("stray_done_no_write", en_write, 0);
      check_output("stray_done_grant", grant, 3'b010);

      apply_stimulus(1'b1, 3'b000, 3'b000);
      tick();
      tick();
      req = 3'b001;
      tick();
      check_output("pe_grant", grant, 3'b001);
      wr_req = 3'b100;
      tick();
      wr_req = 3'b000;
      check_output("pe_flag", proto_err, 1);
      check_output("pe_no_write", en_write, 0);
      check_output("pe_grant_kept", grant, 3'b001);
      tick();
      check_output("pe_flag_pulse", proto_err, 0);
      wr_req = 3'b001;
      tick();
      wr_req = 3'b000;
      check_output("pe_ok_write", en_write, 1);
      wr_req = 3'b001;
      tick();
      wr_req = 3'b000;
      check_output("pe_wait_flag", proto_err, 1);
      check_output("pe_wait_no_write", en_write, 0);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      req = 3'b000;
      tick();
      tick();

      req = 3'b110;
      tick();
      check_output("burst_first", grant, 3'b010);
      for (int w = 0; w < 4; w++) begin
         do_word(1, 9'h100 + 9'(w), 2);
         check_output("burst_grant", grant, (w < 3) ? 3'b010 : 3'b000);
      end
      wait_grant("burst_switch", 3'b100, 4);
      do_word(2, 9'h0A5, 3);
      req = 3'b010;
      wait_grant("burst_back", 3'b010, 5);
      do_word(1, 9'h104, 1);
      check_output("burst_more", grant, 3'b010);
      do_word(1, 9'h105, 1);
      req = 3'b000;
      tick();
      tick();

      req = 3'b010;
      tick();
      check_output("initfall_grant", grant, 3'b010);
      wr_req = 3'b010;
      wr_data[DATA_W +: DATA_W] = 9'h1F0;
      tick();
      wr_req = 3'b000;
      check_output("initfall_write", en_write, 1);
      init_done = 1'b0;
      tick();
      check_output("initfall_inflight", grant, 3'b010);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      check_output("initfall_release", grant, 3'b000);
      tick();
      tick();
      check_output("initfall_no_regrant", grant, 3'b000);
      apply_stimulus(1'b1, 3'b000, 3'b000);
      tick();

      req = 3'b010;
      tick();
      check_output("rst_pre_grant", grant, 3'b010);
      wr_req = 3'b010;
      tick();
      wr_req = 3'b000;
      #3;
      rst_n = 1'b0;
      #1;
      check_output("rst_async_grant", grant, 0);
      check_output("rst_async_en_write", en_write, 0);
      check_output("rst_async_data", data, 0);
      check_output("rst_async_busy", busy, 0);
      apply_stimulus(1'b1, 3'b110, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_output("rst_first_grant", grant, 3'b010);

      do_reset();
      random_run();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
